prbs_cmd_gen_v2: RTL and testbench

// Parametrised PRBS command-field generator for the memory traffic generator; successor to the fixed-tap address/instr/blen PRBS.

---
 rtl/prbs_gen_pkg.sv | 41 ++++
 rtl/prbs_lfsr_core.sv | 53 +++++
 rtl/prbs_cmd_gen_v2.sv | 166 ++++++++++++++++
 tb/tb_prbs_cmd_gen_v2.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_gen_pkg.sv
// Package: prbs_gen_pkg
// Shared definitions for the PRBS command-field generator:
//   - output mapping mode constants (packed ASCII so they can be
//     compared in generate conditions)
//   - default Galois tap masks for the supported LFSR widths
//   - clog2 helper used for address alignment
package prbs_gen_pkg;

  typedef logic [55:0] mode_t;

  localparam mode_t MODE_ADDRESS = 56'("ADDRESS");
  localparam mode_t MODE_INSTR   = 56'("INSTR");
  localparam mode_t MODE_BLEN    = 56'("BLEN");

  // Maximal-length feedback masks for the Galois form
  // nxt = {lfsr[W-2:0],1'b0} ^ (lfsr[W-1] ? taps : 0).
  // The implicit x^W term is not part of the mask.
  function automatic logic [63:0] defaultTaps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_0000_0000_0071;
      16:      taps = 64'h0000_0000_0000_A011;
      20:      taps = 64'h0000_0000_0002_0001;
      32:      taps = 64'h0000_0000_0040_0007;
      64:      taps = 64'hB000_0000_0000_0001;
      default: taps = 64'h0;
    endcase
    return taps;
  endfunction

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// Module: prbs_lfsr_core
// Galois LFSR register with synchronous reseed and step enable.
// A zero seed is replaced by 1 so the register can never lock up.
// Ports:
//   clk_i        clock
//   rst_n_i      asynchronous active-low reset (state <- SEED_DEFAULT)
//   seed_init_i  load seed_i this cycle; overrides step_i
//   seed_i       seed value
//   step_i       advance the LFSR by one step
//   state_o      current LFSR state
module prbs_lfsr_core
  import prbs_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(defaultTaps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             seed_init_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] stepped;

  // Next-state selection: reseed has priority over stepping; a zero
  // seed is substituted with 1 because all-zero is the LFSR's dead state.
  always_comb begin
    stepped = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? TAPS : '0);
    state_d = state_q;
    if (seed_init_i) begin
      state_d = (seed_i == '0) ? WIDTH'(1) : seed_i;
    end else if (step_i) begin
      state_d = stepped;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SEED_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/prbs_cmd_gen_v2.sv
// Module: prbs_cmd_gen_v2
// PRBS command-field generator for the memory traffic generator.
// The LFSR state is mapped (address window / instruction / burst length)
// into a registered valid/ready output; the LFSR only advances when a
// new value is loaded, so back-pressure never skips a value.
// Ports:
//   clk_i           clock
//   rst_n_i         asynchronous active-low reset
//   prbs_seed_init  synchronous reseed, highest priority
//   prbs_seed_i     seed value sampled with prbs_seed_init
//   clk_en          allows a new value to be generated
//   cmd_ready_i     downstream accepts cmd_o this cycle
//   cmd_valid_o     cmd_o holds a valid value
//   cmd_o           generated field
//   cmd_count_o     accepted commands since reset/reseed (saturating)
module prbs_cmd_gen_v2
  import prbs_gen_pkg::*;
#(
  parameter int                    TCQ          = 100,
  parameter mode_t                 MODE         = MODE_ADDRESS,
  parameter int unsigned           LFSR_WIDTH   = 32,
  parameter logic [LFSR_WIDTH-1:0] TAPS         = LFSR_WIDTH'(defaultTaps(LFSR_WIDTH)),
  parameter logic [LFSR_WIDTH-1:0] SEED_DEFAULT = LFSR_WIDTH'(1),
  parameter int unsigned           ADDR_WIDTH   = 29,
  parameter int unsigned           DWIDTH       = 32,
  parameter logic [31:0]           SADDR        = 32'h0000_2000,
  parameter int unsigned           WINDOW_LOG2  = 12,
  parameter int unsigned           BLEN_LOG2    = 6,
  parameter int unsigned           CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  prbs_seed_init,
  input  logic [LFSR_WIDTH-1:0] prbs_seed_i,
  input  logic                  clk_en,
  input  logic                  cmd_ready_i,
  output logic                  cmd_valid_o,
  output logic [ADDR_WIDTH-1:0] cmd_o,
  output logic [CNT_WIDTH-1:0]  cmd_count_o
);

  localparam int unsigned ALIGN      = clog2(DWIDTH / 8);
  localparam logic [63:0] ALIGN_MASK = (64'd1 << ALIGN) - 64'd1;

  // Parameter sanity checks, evaluated at elaboration.
  if (TAPS == '0) begin : gErrTaps
    $error("prbs_cmd_gen_v2: TAPS must be nonzero");
  end
  if (SEED_DEFAULT == '0) begin : gErrSeed
    $error("prbs_cmd_gen_v2: SEED_DEFAULT must be nonzero");
  end
  if (LFSR_WIDTH < 8 || LFSR_WIDTH > 64) begin : gErrWidth
    $error("prbs_cmd_gen_v2: LFSR_WIDTH must be 8..64");
  end
  if (ADDR_WIDTH > LFSR_WIDTH) begin : gErrAddrWidth
    $error("prbs_cmd_gen_v2: ADDR_WIDTH exceeds LFSR_WIDTH");
  end
  if ((64'(SADDR) & ALIGN_MASK) != 64'd0) begin : gErrSaddr
    $error("prbs_cmd_gen_v2: SADDR is not aligned to the data bus");
  end
  if (WINDOW_LOG2 > ADDR_WIDTH) begin : gErrWindow
    $error("prbs_cmd_gen_v2: WINDOW_LOG2 exceeds ADDR_WIDTH");
  end
  if (MODE == MODE_BLEN && BLEN_LOG2 >= ADDR_WIDTH) begin : gErrBlen
    $error("prbs_cmd_gen_v2: burst length does not fit ADDR_WIDTH");
  end
  if (TCQ < 0) begin : gErrTcq
    $error("prbs_cmd_gen_v2: TCQ must be non-negative");
  end

  // Reset is asserted asynchronously but released on a clock edge, so
  // every flop in the block leaves reset in the same cycle.
  logic [1:0] rstSync_q;
  logic       rstSyncN;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rstSync_q <= '0;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncN = rstSync_q[1];

  logic                  cmdValid_q, cmdValid_d;
  logic [ADDR_WIDTH-1:0] cmd_q, cmd_d;
  logic [CNT_WIDTH-1:0]  cmdCount_q, cmdCount_d;
  logic [LFSR_WIDTH-1:0] lfsrState;
  logic [ADDR_WIDTH-1:0] mappedCmd;
  logic                  accept;
  logic                  load;
  logic                  unusedLfsrBits;

  assign accept = cmdValid_q & cmd_ready_i;
  assign load   = clk_en & (~cmdValid_q | cmd_ready_i) & ~prbs_seed_init;

  prbs_lfsr_core #(
    .WIDTH        (LFSR_WIDTH),
    .TAPS         (TAPS),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) uLfsr (
    .clk_i       (clk_i),
    .rst_n_i     (rstSyncN),
    .seed_init_i (prbs_seed_init),
    .seed_i      (prbs_seed_i),
    .step_i      (load),
    .state_o     (lfsrState)
  );

  // Only part of the LFSR state feeds the mapping in each mode.
  assign unusedLfsrBits = ^lfsrState;

  // Mode-specific mapping of the current LFSR state.
  if (MODE == MODE_ADDRESS) begin : gMapAddress
    logic [63:0] windowOff;
    assign windowOff = 64'(lfsrState[WINDOW_LOG2-1:0]) & ~ALIGN_MASK;
    assign mappedCmd = ADDR_WIDTH'(64'(SADDR) + windowOff);
  end else if (MODE == MODE_INSTR) begin : gMapInstr
    assign mappedCmd = ADDR_WIDTH'(lfsrState[2:0]);
  end else if (MODE == MODE_BLEN) begin : gMapBlen
    // Field value 0 becomes 1, full-range field becomes 2**BLEN_LOG2.
    assign mappedCmd = ADDR_WIDTH'(lfsrState[BLEN_LOG2-1:0]) + ADDR_WIDTH'(1);
  end else begin : gMapUnknown
    assign mappedCmd = '0;
    $error("prbs_cmd_gen_v2: unknown MODE");
  end

  // Output/counter next state. The counter first counts the handshake
  // of this cycle; a reseed then clears it, so reseed always wins.
  always_comb begin
    cmd_d      = cmd_q;
    cmdValid_d = cmdValid_q;
    cmdCount_d = cmdCount_q;
    if (accept && (cmdCount_q != '1)) begin
      cmdCount_d = cmdCount_q + CNT_WIDTH'(1);
    end
    if (prbs_seed_init) begin
      cmdValid_d = 1'b0;
      cmdCount_d = '0;
    end else if (load) begin
      cmd_d      = mappedCmd;
      cmdValid_d = 1'b1;
    end else if (accept) begin
      cmdValid_d = 1'b0;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk_i or negedge rstSyncN) begin
    if (!rstSyncN) begin
      cmd_q      <= '0;
      cmdValid_q <= 1'b0;
      cmdCount_q <= '0;
    end else begin
      cmd_q      <= cmd_d;
      cmdValid_q <= cmdValid_d;
      cmdCount_q <= cmdCount_d;
    end
  end

  assign cmd_valid_o = cmdValid_q;
  assign cmd_o       = cmd_q;
  assign cmd_count_o = cmdCount_q;

endmodule

// File: tb/tb_prbs_cmd_gen_v2.sv
// Testbench: tb_prbs_cmd_gen_v2
// Drives an ADDRESS-mode and a BLEN-mode instance from the same stimulus.
// Each reseed pushes the expected output sequence into per-instance
// queues; accepted outputs are popped and compared on the falling edge.
module tb_prbs_cmd_gen_v2;
  import prbs_gen_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        seedInit;
  logic [31:0] seed;
  logic        clkEn;
  logic        ready;

  logic        cmdValidA, cmdValidB;
  logic [28:0] cmdA, cmdB;
  logic [15:0] countA, countB;

  int testCount = 0;
  int failCount = 0;

  logic [28:0] sbAddr[$];
  logic [28:0] sbBlen[$];
  logic [15:0] modelCountA;
  logic [15:0] modelCountB;

  logic [28:0] seqOne[4];

  prbs_cmd_gen_v2 dutAddr (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .prbs_seed_init (seedInit),
    .prbs_seed_i    (seed),
    .clk_en         (clkEn),
    .cmd_ready_i    (ready),
    .cmd_valid_o    (cmdValidA),
    .cmd_o          (cmdA),
    .cmd_count_o    (countA)
  );

  prbs_cmd_gen_v2 #(.MODE(MODE_BLEN)) dutBlen (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .prbs_seed_init (seedInit),
    .prbs_seed_i    (seed),
    .clk_en         (clkEn),
    .cmd_ready_i    (ready),
    .cmd_valid_o    (cmdValidB),
    .cmd_o          (cmdB),
    .cmd_count_o    (countB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: x^32+x^22+x^2+x+1 Galois step and the two mappings.
  function automatic logic [31:0] modelStep(input logic [31:0] s);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ 32'h0040_0007;
    return r;
  endfunction

  function automatic logic [28:0] modelAddr(input logic [31:0] s);
    logic [31:0] off;
    off = {20'd0, s[11:2], 2'b00};
    return 29'(32'h0000_2000 + off);
  endfunction

  function automatic logic [28:0] modelBlen(input logic [31:0] s);
    return {23'd0, s[5:0]} + 29'd1;
  endfunction

  function automatic logic [31:0] effSeed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  task automatic pushSequence(input logic [31:0] seedValue);
    logic [31:0] s;
    s = effSeed(seedValue);
    sbAddr.delete();
    sbBlen.delete();
    for (int i = 0; i < 64; i++) begin
      sbAddr.push_back(modelAddr(s));
      sbBlen.push_back(modelBlen(s));
      s = modelStep(s);
    end
  endtask

  // Reseed both instances and check the one-cycle valid gap, the counter
  // clear and the first value after the seed.
  task automatic applyStimulus(input logic [31:0] seedValue);
    seed     = seedValue;
    seedInit = 1'b1;
    @(posedge clk); #1;
    seedInit = 1'b0;
    checkOutput("seedValidLow", 64'(cmdValidA), 64'(0));
    checkOutput("seedCountClr", 64'(countA), 64'(0));
    modelCountA = '0;
    modelCountB = '0;
    pushSequence(seedValue);
    @(posedge clk); #1;
    checkOutput("seedValidHigh", 64'(cmdValidA), 64'(1));
    checkOutput("seedFirstA", 64'(cmdA), 64'(modelAddr(effSeed(seedValue))));
    checkOutput("seedFirstB", 64'(cmdB), 64'(modelBlen(effSeed(seedValue))));
  endtask

  // Falling-edge monitor: counters every cycle, scoreboard on handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("countA", 64'(countA), 64'(modelCountA));
      checkOutput("countB", 64'(countB), 64'(modelCountB));
      if (cmdValidA && ready) begin
        checkOutput("sbHasA", 64'(sbAddr.size() != 0), 64'(1));
        if (sbAddr.size() != 0) checkOutput("cmdA", 64'(cmdA), 64'(sbAddr.pop_front()));
        if (modelCountA != 16'hFFFF) modelCountA = modelCountA + 16'd1;
      end
      if (cmdValidB && ready) begin
        checkOutput("sbHasB", 64'(sbBlen.size() != 0), 64'(1));
        if (sbBlen.size() != 0) checkOutput("cmdB", 64'(cmdB), 64'(sbBlen.pop_front()));
        if (modelCountB != 16'hFFFF) modelCountB = modelCountB + 16'd1;
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    seqOne[0] = 29'h2000;
    seqOne[1] = 29'h2000;
    seqOne[2] = 29'h2004;
    seqOne[3] = 29'h2008;
    modelCountA = '0;
    modelCountB = '0;
    rst_n    = 1'b0;
    seedInit = 1'b0;
    seed     = '0;
    clkEn    = 1'b0;
    ready    = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValidA", 64'(cmdValidA), 64'(0));
    checkOutput("rstCmdA", 64'(cmdA), 64'(0));
    checkOutput("rstCountA", 64'(countA), 64'(0));
    checkOutput("rstValidB", 64'(cmdValidB), 64'(0));
    checkOutput("rstCmdB", 64'(cmdB), 64'(0));

    // Free run from the reset seed.
    pushSequence(32'h1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    clkEn = 1'b1;
    ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Seed 1: known address sequence, reseed lands during valid&ready.
    applyStimulus(32'h1);
    checkOutput("seq1_0", 64'(cmdA), 64'(seqOne[0]));
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("seq1_n", 64'(cmdA), 64'(seqOne[i]));
    end

    // Back-pressure: output frozen on the pending value.
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bpValid", 64'(cmdValidA), 64'(1));
      checkOutput("bpHold", 64'(cmdA), 64'(sbAddr[0]));
      @(posedge clk); #1;
    end
    ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Zero seed behaves as seed 1.
    applyStimulus(32'h0);
    checkOutput("seq0_0", 64'(cmdA), 64'(seqOne[0]));
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("seq0_n", 64'(cmdA), 64'(seqOne[i]));
    end

    // MSB-only seed exercises the feedback taps.
    applyStimulus(32'h8000_0000);
    checkOutput("msbSeed0", 64'(cmdA), 64'(29'h2000));
    @(posedge clk); #1;
    checkOutput("msbSeed1", 64'(cmdA), 64'(29'h2004));

    // Burst-length range ends.
    applyStimulus(32'h0000_003F);
    checkOutput("blenMax", 64'(cmdB), 64'(29'd64));
    applyStimulus(32'h0000_0040);
    checkOutput("blenMin", 64'(cmdB), 64'(29'd1));

    // Random enable/ready traffic against the scoreboard.
    applyStimulus(32'hDEAD_BEEF);
    for (int i = 0; i < 40; i++) begin
      clkEn = 1'($urandom_range(0, 3) != 0);
      ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    clkEn = 1'b1;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-stream, checked before the next clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 64'(cmdValidA), 64'(0));
    checkOutput("asyncRstCmd", 64'(cmdA), 64'(0));
    checkOutput("asyncRstCount", 64'(countA), 64'(0));
    checkOutput("asyncRstValidB", 64'(cmdValidB), 64'(0));
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
